// File: rtl/seven_seg_serializer.sv
// ---------------------------------------------------------------------------
// seven_seg_serializer
//   Captures a frame of DIGITS x SEGS segment bits on a start pulse. It applies
//   per-digit blanking and an optional half-frame rotation (time/date swap).
//   It then shifts the frame MSB-first out of CHAINS parallel serial lines,
//   which share one serial clock and one latch strobe.
//
//   Optional feature macro: SEVEN_SEG_SERIALIZER_PENDING_EN
//     defined   - a start while busy is remembered (one deep) and launches a
//                 fresh capture in the done cycle
//     undefined - a start while busy is ignored; no pending state exists
//
// Ports
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   start_i   single-cycle frame request
//   data_i    segment data, digit k = data_i[k*SEGS +: SEGS]
//   blank_i   per-digit blank mask (1 zeroes the digit, input positions)
//   rotate_i  swap upper and lower halves of the digit frame
//   busy_o    frame in progress
//   sclk_o    serial clock, downstream samples on rising edge
//   data_o    serial data, one bit per chain
//   latch_o   storage-register latch strobe
//   done_o    one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module seven_seg_serializer #(
  parameter int unsigned DIGITS   = 12,
  parameter int unsigned SEGS     = 7,
  parameter int unsigned CHAINS   = 1,
  parameter int unsigned SCLK_DIV = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [DIGITS*SEGS-1:0]   data_i,
  input  logic [DIGITS-1:0]        blank_i,
  input  logic                     rotate_i,
  output logic                     busy_o,
  output logic                     sclk_o,
  output logic [CHAINS-1:0]        data_o,
  output logic                     latch_o,
  output logic                     done_o
);

  localparam int unsigned W   = DIGITS * SEGS;
  localparam int unsigned HW  = W / 2;
  localparam int unsigned L   = (W + CHAINS - 1) / CHAINS;
  localparam int unsigned PW  = CHAINS * L;
  localparam int unsigned BCW = $clog2(L + 1);
  localparam int unsigned DCW = $clog2(SCLK_DIV + 1);

  // Parameter sanity checks at elaboration
  if ((DIGITS % 2) != 0) begin : g_bad_digits
    $error("seven_seg_serializer: DIGITS must be even");
  end
  if ((CHAINS < 1) || (CHAINS > 8)) begin : g_bad_chains
    $error("seven_seg_serializer: CHAINS must be 1..8");
  end
  if (SCLK_DIV < 1) begin : g_bad_div
    $error("seven_seg_serializer: SCLK_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    sreg_q, sreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [W-1:0]     blanked;
  logic [W-1:0]     rotated;
  logic [PW-1:0]    frame;
  logic             phase_end;
  logic             go;

  logic             busy_d;
  logic             sclk_d;
  logic [CHAINS-1:0] data_d;
  logic             latch_d;
  logic             done_d;

  // Frame preparation: blank by input position, then rotate, then zero-pad on top
  always_comb begin : frame_prep
    blanked = data_i;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (blank_i[k]) begin
        blanked[k*SEGS +: SEGS] = '0;
      end
    end
    rotated = rotate_i ? {blanked[HW-1:0], blanked[W-1:HW]} : blanked;
    frame   = PW'(rotated);
  end

  // Last cycle of the current sclk half-period (or latch window)
  assign phase_end = (div_cnt_q == DCW'(SCLK_DIV - 1));

`ifdef SEVEN_SEG_SERIALIZER_PENDING_EN
  logic pending_q, pending_d;

  // One-deep request memory; consumed by the capture in the next idle cycle
  always_comb begin : pending_next
    pending_d = pending_q;
    if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (start_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : pending_reg
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign go = start_i | pending_q;
`else
  assign go = start_i;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin : next_state
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = SHIFT_LO;
          sreg_d    = frame;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          div_cnt_d = '0;
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          state_d   = (bit_cnt_d == BCW'(L)) ? LATCH : SHIFT_LO;
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      LATCH: begin
        if (phase_end) begin
          div_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin : output_decode
    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    done_d  = (state_q == LATCH) && (state_d == IDLE);
    data_d  = '0;
    if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) begin
      for (int c = 0; c < int'(CHAINS); c++) begin
        data_d[c] = sreg_d[c*L + L - 1];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin : datapath_reg
    if (!rst_ni) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin : output_reg
    if (!rst_ni) begin
      busy_o  <= 1'b0;
      sclk_o  <= 1'b0;
      data_o  <= '0;
      latch_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      busy_o  <= busy_d;
      sclk_o  <= sclk_d;
      data_o  <= data_d;
      latch_o <= latch_d;
      done_o  <= done_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_serializer.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_serializer
//   Self-checking bench for seven_seg_serializer (DIGITS=2, SEGS=7, CHAINS=3,
//   SCLK_DIV=2: L=5, latch in cycles 21-22, done in cycle 23).
//   Expected values come from a digit-level frame model and from the frame
//   timing formulas; the bench follows SEVEN_SEG_SERIALIZER_PENDING_EN too.
// ---------------------------------------------------------------------------
module tb_seven_seg_serializer;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned SEGS     = 7;
  localparam int unsigned CHAINS   = 3;
  localparam int unsigned SCLK_DIV = 2;
  localparam int unsigned W        = DIGITS * SEGS;
  localparam int unsigned L        = (W + CHAINS - 1) / CHAINS;
  localparam int unsigned PW       = CHAINS * L;
  localparam int          T_LATCH  = int'(2 * SCLK_DIV * L + 1);
  localparam int          T_DONE   = int'(2 * SCLK_DIV * L + SCLK_DIV + 1);

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [W-1:0]      data_i;
  logic [DIGITS-1:0] blank_i;
  logic              rotate_i;
  logic              busy_o;
  logic              sclk_o;
  logic [CHAINS-1:0] data_o;
  logic              latch_o;
  logic              done_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_serializer #(
    .DIGITS   (DIGITS),
    .SEGS     (SEGS),
    .CHAINS   (CHAINS),
    .SCLK_DIV (SCLK_DIV)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .data_i   (data_i),
    .blank_i  (blank_i),
    .rotate_i (rotate_i),
    .busy_o   (busy_o),
    .sclk_o   (sclk_o),
    .data_o   (data_o),
    .latch_o  (latch_o),
    .done_o   (done_o)
  );

  // Digit-level reference: blank digits, swap halves of the digit list, pad
  function automatic logic [PW-1:0] model_frame(input logic [W-1:0] d,
                                                input logic [DIGITS-1:0] bl,
                                                input logic rot);
    logic [SEGS-1:0] dig [DIGITS];
    logic [PW-1:0]   f;
    int              src;
    f = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      dig[k] = bl[k] ? '0 : d[k*SEGS +: SEGS];
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      src = rot ? (k + int'(DIGITS) / 2) % int'(DIGITS) : k;
      f[k*SEGS +: SEGS] = dig[src];
    end
    return f;
  endfunction

  // Runs one frame (optionally already started in the current cycle), checks
  // every cycle against the timing formulas, and returns the bits seen on data_o.
  task automatic run_frame(input logic [W-1:0] d, input logic [DIGITS-1:0] bl,
                           input logic rot, input bit pre_started,
                           input int extra_start, input string name,
                           output logic [PW-1:0] got);
    logic [PW-1:0]     exp_frame;
    logic              e_busy, e_sclk, e_latch, e_done;
    logic [CHAINS-1:0] e_data;
    int                b, ph;
    exp_frame = model_frame(d, bl, rot);
    got = '0;
    if (!pre_started) begin
      @(negedge clk);
      data_i   = d;
      blank_i  = bl;
      rotate_i = rot;
      start_i  = 1'b1;
    end
    for (int t = 1; t <= T_DONE; t++) begin
      @(negedge clk);
      e_busy = 1'b0; e_sclk = 1'b0; e_latch = 1'b0; e_done = 1'b0; e_data = '0;
      if (t < T_LATCH) begin
        b  = (t - 1) / int'(2 * SCLK_DIV);
        ph = (t - 1) % int'(2 * SCLK_DIV);
        e_busy = 1'b1;
        e_sclk = (ph >= int'(SCLK_DIV));
        for (int c = 0; c < int'(CHAINS); c++) begin
          e_data[c] = exp_frame[c*int'(L) + int'(L) - 1 - b];
          if (ph == 0) got[c*int'(L) + int'(L) - 1 - b] = data_o[c];
        end
      end else if (t < T_DONE) begin
        e_busy  = 1'b1;
        e_latch = 1'b1;
      end else begin
        e_done = 1'b1;
      end
      tests++;
      if ({busy_o, sclk_o, data_o, latch_o, done_o} !==
          {e_busy, e_sclk, e_data, e_latch, e_done}) begin
        fails++;
        $display("FAIL %s cycle %0d busy/sclk/data/latch/done: got %b %b %b %b %b, expected %b %b %b %b %b",
                 name, t, busy_o, sclk_o, data_o, latch_o, done_o,
                 e_busy, e_sclk, e_data, e_latch, e_done);
      end
      if (t < T_DONE) begin
        start_i  = (t == extra_start);
        data_i   = W'($urandom);
        blank_i  = DIGITS'($urandom);
        rotate_i = 1'($urandom);
      end
    end
    tests++;
    if (got !== exp_frame) begin
      fails++;
      $display("FAIL %s shifted frame: got %h, expected %h", name, got, exp_frame);
    end
  endtask

  task automatic test_reset();
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    data_i   = '0;
    blank_i  = '0;
    rotate_i = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy_o, sclk_o, data_o, latch_o, done_o} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got %b, expected 0", {busy_o, sclk_o, data_o, latch_o, done_o});
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy_o, sclk_o, data_o, latch_o, done_o} !== '0) begin
      fails++;
      $display("FAIL idle after reset: got %b, expected 0", {busy_o, sclk_o, data_o, latch_o, done_o});
    end
  endtask

  task automatic test_basic_frame();
    logic [PW-1:0] got;
    run_frame(W'(14'h2A5B), '0, 1'b0, 1'b0, 0, "basic", got);
    tests++;
    if (got !== PW'(14'h2A5B)) begin
      fails++;
      $display("FAIL basic word: got %h, expected %h", got, PW'(14'h2A5B));
    end
  endtask

  task automatic test_blank_rotate();
    logic [PW-1:0] got;
    run_frame(W'(14'h2A5B), DIGITS'(2'b01), 1'b1, 1'b0, 0, "blank_rotate", got);
    tests++;
    if (got !== PW'(14'h0054)) begin
      fails++;
      $display("FAIL blank_rotate word: got %h, expected %h", got, PW'(14'h0054));
    end
  endtask

  task automatic test_multi_chain();
    logic [PW-1:0] got;
    run_frame(W'(14'h3FFF), '0, 1'b0, 1'b0, 0, "multi_chain", got);
    tests++;
    if (got !== PW'(15'h3FFF)) begin
      fails++;
      $display("FAIL multi_chain word: got %h, expected %h", got, PW'(15'h3FFF));
    end
  endtask

  task automatic test_random_frames();
    logic [PW-1:0] got;
    for (int i = 0; i < 8; i++) begin
      run_frame(W'($urandom), DIGITS'($urandom), 1'($urandom), 1'b0, 0, "random", got);
    end
  endtask

  // Start asserted in the done cycle must launch the next frame with no gap
  task automatic test_back_to_back();
    logic [PW-1:0] got;
    run_frame(W'($urandom), DIGITS'($urandom), 1'($urandom), 1'b0, 0, "b2b_first", got);
    for (int i = 0; i < 3; i++) begin
      data_i   = W'($urandom);
      blank_i  = DIGITS'($urandom);
      rotate_i = 1'($urandom);
      start_i  = 1'b1;
      run_frame(data_i, blank_i, rotate_i, 1'b1, 0, "b2b_next", got);
    end
  endtask

  // Start in cycle 5 while busy: pending build relaunches in the done cycle
  task automatic test_pending();
    logic [PW-1:0] got;
    run_frame(W'($urandom), DIGITS'($urandom), 1'($urandom), 1'b0, 5, "pend_first", got);
`ifdef SEVEN_SEG_SERIALIZER_PENDING_EN
    run_frame(data_i, blank_i, rotate_i, 1'b1, 0, "pend_second", got);
`else
    for (int t = 1; t <= T_DONE; t++) begin
      @(negedge clk);
      tests++;
      if ((busy_o !== 1'b0) || (done_o !== 1'b0)) begin
        fails++;
        $display("FAIL ignored_start cycle %0d busy/done: got %b %b, expected 0 0",
                 t, busy_o, done_o);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    data_i   = W'($urandom);
    blank_i  = '0;
    rotate_i = 1'b0;
    start_i  = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_frame busy before reset: got %b, expected 1", busy_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({busy_o, sclk_o, data_o, latch_o, done_o} !== '0) begin
      fails++;
      $display("FAIL mid_frame reset outputs: got %b, expected 0", {busy_o, sclk_o, data_o, latch_o, done_o});
    end
    @(negedge clk);
    rst_ni = 1'b1;
    for (int t = 0; t < T_DONE + 4; t++) begin
      @(negedge clk);
      tests++;
      if ({busy_o, sclk_o, data_o, latch_o, done_o} !== '0) begin
        fails++;
        $display("FAIL after_abort cycle %0d outputs: got %b, expected 0",
                 t, {busy_o, sclk_o, data_o, latch_o, done_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_blank_rotate();
    test_multi_chain();
    test_random_frames();
    test_back_to_back();
    test_pending();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_serializer.md
# seven_seg_serializer

Parametrised successor to the single-chain seven-segment shift-register output path of the MSF clock. It captures a frame of DIGITS×SEGS segment bits on a start pulse and applies per-digit blanking and an optional half-frame rotation (time/date swap). It then shifts the frame MSB-first out of CHAINS parallel data lines with a shared serial clock and latch strobe. It sits between `seven_seg_digits` and the external shift-register chain(s), replacing the fixed year-blanking and `time_date_shift` logic.

## Interface
- DIGITS, 12: number of digits per frame; must be even (elaboration error otherwise).
- SEGS, 7: bits per digit.
- CHAINS, 1: parallel output chains, 1..8.
- SCLK_DIV, 1: clock cycles per sclk half-period, ≥1.
- Derived values:
  - W = DIGITS*SEGS.
  - L = ceil(W/CHAINS), the bits per chain.

- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle request to send a frame
- data_i  in  W  segment data; digit k = data_i[k*SEGS +: SEGS]
- blank_i  in  DIGITS  per-digit blank mask; 1 forces that digit's bits to 0
- rotate_i  in  1  swap upper and lower DIGITS/2 digits
- busy_o  out  1  frame in progress
- sclk_o  out  1  serial clock; downstream samples on rising edge
- data_o  out  CHAINS  serial data, one bit per chain
- latch_o  out  1  storage-register latch strobe
- done_o  out  1  one-cycle pulse when a frame completes

## Operation
- Frame preparation is combinational and sampled only on the capture cycle:
  - Blank: B = data_i with digit k zeroed where blank_i[k]=1. Blanking indexes input positions, before rotation.
  - Rotate: if rotate_i, R = {B[W/2-1:0], B[W-1:W/2]}, else R = B.
  - Pad: P = {(CHAINS*L-W) zeros, R}.
  - Chain c shifts P[(c+1)*L-1 : c*L], MSB first.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE: on start_i, capture P into the shift register, clear the bit counter, and go to SHIFT_LO.
  - SHIFT_LO: sclk_o=0 and data_o = current MSBs, held for SCLK_DIV cycles. Then go to SHIFT_HI.
  - SHIFT_HI: sclk_o=1, held for SCLK_DIV cycles. Then shift left and increment the bit counter.
    - If the counter reaches L, go to LATCH.
    - Otherwise go to SHIFT_LO.
  - LATCH: sclk_o=0, data_o=0, latch_o=1 for SCLK_DIV cycles. Then go to IDLE and assert done_o for one cycle.
- busy_o = (state != IDLE).
- data_o is stable for the whole SHIFT_LO/SHIFT_HI pair of each bit.
- Counters are sized from clog2(L+1) and clog2(SCLK_DIV+1). Nothing wraps within a frame.
- Outputs are registered. No combinational path from any input to any output.
- Reset (any time, including mid-frame):
  - All outputs go to 0 immediately.
  - FSM returns to IDLE; shift register, counters and pending flag are cleared.
  - The aborted frame is not resumed.

## Timing
- start_i accepted in cycle 0 (IDLE).
- busy_o and sclk_o=0 with the first bit are valid from cycle 1.
- First sclk rising edge is at cycle 1+SCLK_DIV.
- latch_o is high for cycles 2*SCLK_DIV*L+1 .. 2*SCLK_DIV*L+SCLK_DIV.
- done_o pulses in cycle 2*SCLK_DIV*L+SCLK_DIV+1, the first IDLE cycle, with busy_o=0.
- A start_i in the same cycle as done_o is accepted as a fresh start.
- data_i, blank_i and rotate_i changes after the capture cycle do not affect the frame in flight.

## Configuration
- Macro SEVEN_SEG_SERIALIZER_PENDING_EN.
- Defined:
  - start_i while busy sets a one-deep pending flag. Further starts while pending are merged.
  - In the done_o cycle, a pending flag acts as start_i: a fresh capture of the inputs in that cycle, and the flag clears.
- Undefined:
  - start_i while busy is ignored.
  - No pending state is synthesised.

## Test plan
- Reset mid-frame:
  - DIGITS=2, SEGS=7, CHAINS=1, SCLK_DIV=1; start frame, assert rst_ni=0 in cycle 10.
  - Expect: all outputs 0 that cycle; after release, busy_o=0; no done_o.
- Basic frame:
  - Same parameters; data_i=14'h2A5B, blank_i=0, rotate_i=0, start_i at cycle 0.
  - Expect:
    - 14 sclk rising edges at cycles 2,4,…,28.
    - data_o sequence 1,0,1,0,1,0,0,1,0,1,1,0,1,1.
    - latch_o at cycle 29; done_o at cycle 30.
- Blank and rotate:
  - data_i=14'h2A5B, blank_i=2'b01, rotate_i=1.
  - Expect shifted word 14'h0054, i.e. {7'h00, 7'h54}.
- Multi-chain padding:
  - CHAINS=3, SCLK_DIV=2, data_i=14'h3FFF.
  - Expect: L=5; chain 2 emits 0,1,1,1,1; chains 0 and 1 emit all 1s.
  - Expect latch_o for cycles 21–22 and done_o at cycle 23.
- Pending (macro defined):
  - start_i at cycles 0 and 5.
  - Expect a second capture at cycle 30 (done_o cycle) and busy_o from cycle 31.
  - Without the macro: busy_o stays 0 after cycle 30.
- Start coincident with done_o:
  - Expect it accepted, busy_o at next cycle, no lost frame.
